// File: rtl/mmio_slot_master.sv
// Slot-bus initiator: CPU request/response to single-cycle slot strobes.
// Optional MMIO_SLOT_DECODE_ERR_EN flags requests with upper address bits set.
module mmio_slot_master #(
  parameter int NUM_SLOTS = 64,
  parameter int ADDR_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bus_req,
  input  logic                    bus_we,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic [31:0]             bus_wdata,
  output logic                    bus_ready,
  output logic                    bus_rvalid,
  output logic [31:0]             bus_rdata,
  output logic                    bus_err,
  output logic [NUM_SLOTS-1:0]    slot_cs,
  output logic                    slot_read,
  output logic                    slot_write,
  output logic [4:0]              slot_reg_addr,
  output logic [31:0]             slot_wr_data,
  input  logic [NUM_SLOTS*32-1:0] slot_rd_data
);

  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int HI_LSB    = 5 + SLOT_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_we;
  logic                 r_err;
  logic [SLOT_BITS-1:0] r_slot;
  logic [4:0]           r_reg;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;

  logic        w_accept;
  logic        w_unmapped;
  logic [31:0] w_rd_sel;

  // Any set bit above the slot field marks the request as unmapped.
`ifdef MMIO_SLOT_DECODE_ERR_EN
  generate
    if (ADDR_W > HI_LSB) begin : g_hi
      assign w_unmapped = |bus_addr[ADDR_W-1:HI_LSB];
    end else begin : g_nohi
      assign w_unmapped = 1'b0;
    end
  endgenerate
`else
  generate
    if (ADDR_W > HI_LSB) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^bus_addr[ADDR_W-1:HI_LSB];
    end
  endgenerate
  assign w_unmapped = 1'b0;
`endif

  assign w_accept      = (r_state == IDLE) && bus_req;
  assign w_rd_sel      = slot_rd_data[{r_slot, 5'd0} +: 32];
  assign slot_reg_addr = r_reg;
  assign slot_wr_data  = r_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_slot  <= '0;
      r_reg   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= bus_we;
        r_err   <= w_unmapped;
        r_slot  <= bus_addr[HI_LSB-1:5];
        r_reg   <= bus_addr[4:0];
        r_wdata <= bus_wdata;
      end
      if (r_state == ACCESS) begin
        r_rdata <= (r_we || r_err) ? 32'd0 : w_rd_sel;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus_ready   = 1'b0;
    bus_rvalid  = 1'b0;
    bus_rdata   = '0;
    bus_err     = 1'b0;
    slot_cs     = '0;
    slot_read   = 1'b0;
    slot_write  = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus_ready = 1'b1;
        if (bus_req) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!r_err) begin
          slot_cs[r_slot] = 1'b1;
          slot_write      = r_we;
          slot_read       = ~r_we;
        end
        w_state_nxt = RESP;
      end
      RESP: begin
        bus_rvalid  = 1'b1;
        bus_rdata   = r_rdata;
        bus_err     = r_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_slot_master.sv
// Directed bench for mmio_slot_master with a combinational slot model.
// Decode expectations follow MMIO_SLOT_DECODE_ERR_EN.
module tb_mmio_slot_master;

  localparam int NUM_SLOTS = 64;
  localparam int ADDR_W    = 16;

  logic                    clk;
  logic                    reset;
  logic                    bus_req;
  logic                    bus_we;
  logic [ADDR_W-1:0]       bus_addr;
  logic [31:0]             bus_wdata;
  logic                    bus_ready;
  logic                    bus_rvalid;
  logic [31:0]             bus_rdata;
  logic                    bus_err;
  logic [NUM_SLOTS-1:0]    slot_cs;
  logic                    slot_read;
  logic                    slot_write;
  logic [4:0]              slot_reg_addr;
  logic [31:0]             slot_wr_data;
  logic [NUM_SLOTS*32-1:0] slot_rd_data;

  int ntests;
  int nfail;

  mmio_slot_master #(
    .NUM_SLOTS(NUM_SLOTS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ready    (bus_ready),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .bus_err      (bus_err),
    .slot_cs      (slot_cs),
    .slot_read    (slot_read),
    .slot_write   (slot_write),
    .slot_reg_addr(slot_reg_addr),
    .slot_wr_data (slot_wr_data),
    .slot_rd_data (slot_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot k returns {0x5A00|k, 11'b0, reg}; slots 3 and 63 have fixed values.
  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_rd_data[32*k +: 32] = {16'h5A00 | 16'(k), 11'd0, slot_reg_addr};
    end
    if (slot_reg_addr == 5'd3) slot_rd_data[32*3 +: 32] = 32'h1234_5678;
    slot_rd_data[32*63 +: 32] = 32'hDEAD_BEEF;
  end

  task automatic chk1(input string name, input logic got, input logic exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    #1;
    chk1 ("rst_ready",   bus_ready,  1'b1);
    chk1 ("rst_rvalid",  bus_rvalid, 1'b0);
    chk32("rst_rdata",   bus_rdata,  32'd0);
    chk1 ("rst_err",     bus_err,    1'b0);
    chk64("rst_cs",      slot_cs,    64'd0);
    chk1 ("rst_read",    slot_read,  1'b0);
    chk1 ("rst_write",   slot_write, 1'b0);
    chk32("rst_regaddr", {27'd0, slot_reg_addr}, 32'd0);
    chk32("rst_wrdata",  slot_wr_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_rel_ready", bus_ready, 1'b1);
  endtask

  task automatic test_write();
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 16'h0061;
    bus_wdata = 32'h0000_00FF;
    @(negedge clk);
    bus_req   = 1'b0;
    bus_addr  = 16'h07E4;
    bus_wdata = 32'hCAFE_F00D;
    chk64("wr_cs",      slot_cs,    64'h8);
    chk1 ("wr_write",   slot_write, 1'b1);
    chk1 ("wr_read",    slot_read,  1'b0);
    chk1 ("wr_ready",   bus_ready,  1'b0);
    chk1 ("wr_rv_acc",  bus_rvalid, 1'b0);
    chk32("wr_regaddr", {27'd0, slot_reg_addr}, 32'd1);
    chk32("wr_wrdata",  slot_wr_data, 32'h0000_00FF);
    @(negedge clk);
    chk1 ("wr_rvalid",   bus_rvalid, 1'b1);
    chk32("wr_rdata",    bus_rdata,  32'd0);
    chk1 ("wr_err",      bus_err,    1'b0);
    chk1 ("wr_write_off", slot_write, 1'b0);
    chk64("wr_cs_off",   slot_cs,    64'd0);
    @(negedge clk);
    chk1("wr_rv_done", bus_rvalid, 1'b0);
    chk1("wr_idle",    bus_ready,  1'b1);
  endtask

  task automatic test_read();
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 16'h0063;
    @(negedge clk);
    bus_req = 1'b0;
    chk64("rd_cs",    slot_cs,    64'h8);
    chk1 ("rd_read",  slot_read,  1'b1);
    chk1 ("rd_write", slot_write, 1'b0);
    @(negedge clk);
    chk1 ("rd_rvalid",   bus_rvalid, 1'b1);
    chk32("rd_rdata",    bus_rdata,  32'h1234_5678);
    chk1 ("rd_err",      bus_err,    1'b0);
    chk1 ("rd_read_off", slot_read,  1'b0);
    @(negedge clk);
    chk32("rd_rdata_off", bus_rdata, 32'd0);
  endtask

  task automatic test_back_to_back();
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 16'h0000;
    chk1("b2b_ready0", bus_ready, 1'b1);
    @(negedge clk);
    bus_addr = 16'h07FF;
    chk1 ("b2b_ready1", bus_ready, 1'b0);
    chk64("b2b_cs0",    slot_cs,   64'h1);
    @(negedge clk);
    chk1 ("b2b_ready2", bus_ready,  1'b0);
    chk1 ("b2b_rv0",    bus_rvalid, 1'b1);
    chk32("b2b_rdata0", bus_rdata,  32'h5A00_0000);
    @(negedge clk);
    chk1("b2b_ready3", bus_ready,  1'b1);
    chk1("b2b_rv_gap", bus_rvalid, 1'b0);
    @(negedge clk);
    bus_req = 1'b0;
    chk64("b2b_cs63",   slot_cs,   64'h8000_0000_0000_0000);
    chk1 ("b2b_read63", slot_read, 1'b1);
    chk32("b2b_reg31",  {27'd0, slot_reg_addr}, 32'd31);
    @(negedge clk);
    chk1 ("b2b_rv1",    bus_rvalid, 1'b1);
    chk32("b2b_rdata1", bus_rdata,  32'hDEAD_BEEF);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 16'h00A2;
    bus_wdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_req = 1'b0;
    chk1("mid_write_on", slot_write, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk1 ("mid_write_drop", slot_write, 1'b0);
    chk64("mid_cs_drop",    slot_cs,    64'd0);
    @(negedge clk);
    chk1("mid_no_rvalid", bus_rvalid, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk1("mid_no_rvalid2", bus_rvalid, 1'b0);
    chk1("mid_ready",      bus_ready,  1'b1);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 16'h00A7;
    @(negedge clk);
    bus_req = 1'b0;
    chk64("mid_cs5", slot_cs, 64'h20);
    @(negedge clk);
    chk1 ("mid_rv",    bus_rvalid, 1'b1);
    chk32("mid_rdata", bus_rdata,  32'h5A05_0007);
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic       seen_cs;
    logic       seen_strobe;
    seen_cs     = 1'b0;
    seen_strobe = 1'b0;
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 16'h0803;
    @(negedge clk);
    bus_req = 1'b0;
`ifdef MMIO_SLOT_DECODE_ERR_EN
    seen_cs     = |slot_cs;
    seen_strobe = slot_read | slot_write;
    @(negedge clk);
    seen_cs     = seen_cs | (|slot_cs);
    seen_strobe = seen_strobe | slot_read | slot_write;
    chk1 ("dec_no_cs",     seen_cs,     1'b0);
    chk1 ("dec_no_strobe", seen_strobe, 1'b0);
    chk1 ("dec_rvalid",    bus_rvalid,  1'b1);
    chk1 ("dec_err",       bus_err,     1'b1);
    chk32("dec_rdata",     bus_rdata,   32'd0);
`else
    chk64("alias_cs",   slot_cs,   64'h1);
    chk1 ("alias_read", slot_read, 1'b1);
    chk32("alias_reg",  {27'd0, slot_reg_addr}, 32'd3);
    @(negedge clk);
    chk1 ("alias_rvalid", bus_rvalid, 1'b1);
    chk1 ("alias_err",    bus_err,    1'b0);
    chk32("alias_rdata",  bus_rdata,  32'h5A00_0003);
`endif
    @(negedge clk);
    chk1("dec_err_off", bus_err, 1'b0);
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
